// File: rtl/ext_mem_pkg.sv
// Shared types for the external-memory responder: FSM state encoding and the
// data word returned for out-of-range reads.
package ext_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ext_mem_array.sv
// Single-port DEPTH x DATA_W RAM: synchronous write, registered read. The read
// register holds its value until the next read and is the only state cleared by reset.
module ext_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_mem_responder.sv
// Target side of the CPU external-memory bus: wait-state FSM in front of a word RAM.
// Define EXT_MEM_ERR_EN to add the err port and out-of-range address checking.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chip_select,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              busy,
  output state_e            state_dbg
`ifdef EXT_MEM_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              oob_q, oob_d;
  logic              req_oob;
  logic              op_fire;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_rdata;

`ifdef EXT_MEM_ERR_EN
  assign req_oob = ({1'b0, addr} >= (ADDR_W + 1)'(DEPTH));
`else
  // Upper address bits are deliberately dropped: accesses alias modulo DEPTH.
  logic unused_addr_hi;
  assign req_oob        = 1'b0;
  assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    oob_d   = oob_q;
    unique case (state_q)
      IDLE: begin
        if (chip_select) begin
          wr_d   = wr;
          idx_d  = addr[IDX_W-1:0];
          data_d = wr_data;
          oob_d  = req_oob;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM acts on the edge that enters RESP; the *_d fields carry either the live
  // request (zero-wait path straight from IDLE) or the captured one.
  assign op_fire = (state_d == RESP) && (state_q != RESP);
  assign ram_we  = op_fire && wr_d && !oob_d && rst;
  assign ram_re  = op_fire && !wr_d && !oob_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oob_q   <= oob_d;
    end
  end

  ext_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .idx_i   (idx_d),
    .wdata_i (data_d),
    .rdata_o (ram_rdata)
  );

`ifdef EXT_MEM_ERR_EN
  logic rd_err_q, err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_err_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= op_fire && oob_d;
      if (op_fire && !wr_d) begin
        rd_err_q <= oob_d;
      end
    end
  end

  assign rd_data = rd_err_q ? DATA_W'(ERR_DATA) : ram_rdata;
  assign err     = err_q;
`else
  assign rd_data = ram_rdata;
`endif

  assign ready     = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: three instances (WAIT_CYCLES 0, 1, 2) share one request
// stream; a transaction-level model per instance predicts ready/busy/err/rd_data every cycle.
module tb_ext_mem_responder;
  import ext_mem_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;
  localparam int N     = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs  = 1'b0;
  logic          wr  = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;

  logic [N-1:0][DW-1:0] rd_data;
  logic [N-1:0]         ready, busy, err;
  logic [N-1:0][1:0]    sdbg;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ext_mem_responder #(
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (g)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .chip_select (cs),
      .wr          (wr),
      .addr        (addr),
      .wr_data     (wdata),
      .rd_data     (rd_data[g]),
      .ready       (ready[g]),
      .busy        (busy[g]),
      .state_dbg   (sdbg[g])
`ifdef EXT_MEM_ERR_EN
      ,
      .err         (err[g])
`endif
    );
  end

`ifndef EXT_MEM_ERR_EN
  assign err = '0;
`endif

  // ---------------- behavioural model ----------------
  // Each access: accepted at edge k when idle, memory effect at edge k+W, ready for
  // the one cycle after that edge, next request accepted no earlier than edge k+W+2.
  int            edge_n = 0;
  bit            m_active   [N];
  int            m_op_edge  [N];
  int            m_free     [N];
  bit            m_wr       [N];
  logic [AW-1:0] m_addr     [N];
  logic [DW-1:0] m_data     [N];
  bit            m_resp     [N];
  bit            m_err      [N];
  logic [DW-1:0] m_rd       [N];
  bit            m_rd_known [N];
  logic [DW-1:0] m_mem      [N][DEPTH];
  bit            m_known    [N][DEPTH];

  function automatic bit is_oob(input logic [AW-1:0] a);
`ifdef EXT_MEM_ERR_EN
    return int'(a) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < N; g++) begin
        m_active[g]   = 1'b0;
        m_resp[g]     = 1'b0;
        m_err[g]      = 1'b0;
        m_rd[g]       = '0;
        m_rd_known[g] = 1'b1;
        m_free[g]     = 0;
      end
    end else begin
      edge_n++;
      for (int g = 0; g < N; g++) begin
        m_resp[g] = 1'b0;
        m_err[g]  = 1'b0;
        if (!m_active[g] && edge_n >= m_free[g] && cs) begin
          m_active[g]  = 1'b1;
          m_op_edge[g] = edge_n + g;
          m_wr[g]      = wr;
          m_addr[g]    = addr;
          m_data[g]    = wdata;
        end
        if (m_active[g] && edge_n == m_op_edge[g]) begin
          int idx;
          bit oob;
          idx = int'(m_addr[g]) % DEPTH;
          oob = is_oob(m_addr[g]);
          m_active[g] = 1'b0;
          m_resp[g]   = 1'b1;
          m_err[g]    = oob;
          m_free[g]   = edge_n + 2;
          if (m_wr[g]) begin
            if (!oob) begin
              m_mem[g][idx]   = m_data[g];
              m_known[g][idx] = 1'b1;
            end
          end else if (oob) begin
            m_rd[g]       = ERR_DATA;
            m_rd_known[g] = 1'b1;
          end else begin
            m_rd[g]       = m_mem[g][idx];
            m_rd_known[g] = m_known[g][idx];
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  function automatic void check(input string name, input int g,
                                input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %h expected %h", name, g, act, exp);
    end
  endfunction

  int neg_n = 0;
  int ready_cnt      [N];
  int busy_cnt       [N];
  int err_cnt        [N];
  int last_ready_neg [N];

  always @(negedge clk) begin
    neg_n++;
    for (int g = 0; g < N; g++) begin
      check("ready", g, DW'(ready[g]), DW'(m_resp[g]));
      check("busy", g, DW'(busy[g]), DW'(m_active[g] || m_resp[g]));
      check("err", g, DW'(err[g]), DW'(m_resp[g] && m_err[g]));
      if (m_rd_known[g]) check("rd_data", g, rd_data[g], m_rd[g]);
      if (ready[g]) begin
        ready_cnt[g]++;
        last_ready_neg[g] = neg_n;
      end
      if (busy[g]) busy_cnt[g]++;
      if (err[g]) err_cnt[g]++;
    end
  end

  // ---------------- driver tasks ----------------
  int mark_neg;
  int rb [N];
  int bb [N];
  int eb [N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cs    = c;
    wr    = w;
    addr  = a;
    wdata = d;
  endtask

  // One isolated access; leaves all instances idle again.
  task automatic single(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step();
    mark_neg = neg_n;
    for (int g = 0; g < N; g++) begin
      rb[g] = ready_cnt[g];
      bb[g] = busy_cnt[g];
      eb[g] = err_cnt[g];
    end
    drive(1'b1, w, a, d);
    step();
    drive(1'b0, 1'b0, '0, '0);
    repeat (4) step();
  endtask

  int exp_busy [N] = '{1, 2, 3};
  int exp_off  [N] = '{2, 3, 4};

  initial begin
    // reset state
    drive(1'b0, 1'b0, '0, '0);
    repeat (3) step();
    for (int g = 0; g < N; g++) begin
      check("reset_rd_data", g, rd_data[g], 32'h0);
      check("reset_ready", g, DW'(ready[g]), 32'h0);
      check("reset_busy", g, DW'(busy[g]), 32'h0);
      check("reset_state", g, DW'(sdbg[g]), 32'h0);
    end
    rst = 1'b1;
    repeat (2) step();

    // write then read, with latency pins
    single(1'b1, 16'h0010, 32'h1234_5678);
    single(1'b0, 16'h0010, 32'h0);
    for (int g = 0; g < N; g++) begin
      check("t1_rd_data", g, rd_data[g], 32'h1234_5678);
      check("t1_ready_pulses", g, DW'(ready_cnt[g] - rb[g]), 32'd1);
      check("t2_busy_cycles", g, DW'(busy_cnt[g] - bb[g]), DW'(exp_busy[g]));
      check("t2_ready_offset", g, DW'(last_ready_neg[g] - mark_neg), DW'(exp_off[g]));
    end

    // zero-wait back-to-back reads
    single(1'b1, 16'h0001, 32'h0101_0101);
    single(1'b1, 16'h0002, 32'h0202_0202);
    step();
    drive(1'b1, 1'b0, 16'h0001, '0);
    step();
    check("t3_first_read", 0, rd_data[0], 32'h0101_0101);
    drive(1'b1, 1'b0, 16'h0002, '0);
    step();
    check("t3_hold", 0, rd_data[0], 32'h0101_0101);
    step();
    check("t3_second_read", 0, rd_data[0], 32'h0202_0202);
    drive(1'b0, 1'b0, '0, '0);
    repeat (5) step();

    // reset during WAIT aborts the write
    single(1'b1, 16'h0020, 32'h1111_2222);
    step();
    drive(1'b1, 1'b1, 16'h0020, 32'hAAAA_5555);
    step();
    drive(1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    #1;
    for (int g = 0; g < N; g++) begin
      check("t4_rd_data_rst", g, rd_data[g], 32'h0);
      check("t4_ready_rst", g, DW'(ready[g]), 32'h0);
      check("t4_busy_rst", g, DW'(busy[g]), 32'h0);
    end
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    single(1'b0, 16'h0020, 32'h0);
    check("t4_completed_write", 0, rd_data[0], 32'hAAAA_5555);
    check("t4_aborted_write", 1, rd_data[1], 32'h1111_2222);
    check("t4_aborted_write", 2, rd_data[2], 32'h1111_2222);

    // chip_select held for 10 cycles
    step();
    for (int g = 0; g < N; g++) rb[g] = ready_cnt[g];
    drive(1'b1, 1'b0, 16'h0010, '0);
    repeat (10) step();
    drive(1'b0, 1'b0, '0, '0);
    repeat (6) step();
    check("t5_held_pulses", 1, DW'(ready_cnt[1] - rb[1]), 32'd4);

    // address 0x0400: alias of 0x0000, or out of range with the error feature
    single(1'b1, 16'h0000, 32'hCAFE_F00D);
    single(1'b0, 16'h0400, 32'h0);
    for (int g = 0; g < N; g++) begin
`ifdef EXT_MEM_ERR_EN
      check("t6_err_data", g, rd_data[g], 32'hDEAD_BEEF);
      check("t6_err_pulses", g, DW'(err_cnt[g] - eb[g]), 32'd1);
`else
      check("t6_wrap_data", g, rd_data[g], 32'hCAFE_F00D);
      check("t6_err_pulses", g, DW'(err_cnt[g] - eb[g]), 32'd0);
`endif
    end
`ifdef EXT_MEM_ERR_EN
    single(1'b1, 16'h0400, 32'h5A5A_5A5A);
    single(1'b0, 16'h0000, 32'h0);
    for (int g = 0; g < N; g++) check("t6_dropped_write", g, rd_data[g], 32'hCAFE_F00D);
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] hi;
      logic [9:0] lo;
      step();
      if (!rst) rst = 1'b1;
      hi = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      lo = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {hi, lo}, $urandom);
      if ($urandom_range(0, 199) == 0) rst = 1'b0;
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
